// File: rtl/ysyx_23060075_core_ctrl_if.sv
// Control/handshake bundle between the core sequencer (master) and the
// IFU/LSU/datapath side (slave).
interface ysyx_23060075_core_ctrl_if #(
  parameter int RET_WIDTH = 64
);
  logic                 ifu_req_valid;
  logic                 ifu_resp_valid;
  logic                 inst_latch_en;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [11:0]          funct12;
  logic                 br_taken;
  logic                 lsu_req_valid;
  logic                 lsu_req_ready;
  logic                 lsu_resp_valid;
  logic                 gpr_w_en;
  logic                 csr_w_en;
  logic                 is_csri;
  logic                 pc_w_en;
  logic [1:0]           pc_sel;
  logic                 halt;
  logic                 halt_err;
  logic [RET_WIDTH-1:0] minstret;

  modport master (
    output ifu_req_valid, inst_latch_en, lsu_req_valid,
    output gpr_w_en, csr_w_en, is_csri, pc_w_en, pc_sel,
    output halt, halt_err, minstret,
    input  ifu_resp_valid, opcode, funct3, funct12, br_taken,
    input  lsu_req_ready, lsu_resp_valid
  );

  modport slave (
    input  ifu_req_valid, inst_latch_en, lsu_req_valid,
    input  gpr_w_en, csr_w_en, is_csri, pc_w_en, pc_sel,
    input  halt, halt_err, minstret,
    output ifu_resp_valid, opcode, funct3, funct12, br_taken,
    output lsu_req_ready, lsu_resp_valid
  );
endinterface

// File: rtl/ysyx_23060075_core_ctrl.sv
// Multi-cycle RV32 sequencer: IDLE -> FETCH -> DECODE -> EXEC -> [MEM_REQ -> MEM_WAIT] -> WB,
// with an absorbing HALT on ebreak, illegal opcode or bus-wait timeout.
module ysyx_23060075_core_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int TO_WIDTH  = 8,
  parameter int RET_WIDTH = 64
) (
  input logic                        clk,
  input logic                        rst,
  ysyx_23060075_core_ctrl_if.master  bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT
  } state_t;

  state_t               state_q, state_d;
  logic [TO_WIDTH-1:0]  to_q, to_d;
  logic [RET_WIDTH-1:0] ret_q, ret_d;
  logic                 halt_err_q, halt_err_d;
  logic                 br_q, br_d;

  logic is_legal, is_ebreak, is_mem, is_sys, sys_f3_zero;
  logic timed_out;

  assign is_sys      = (bus.opcode == OP_SYSTEM);
  assign sys_f3_zero = is_sys && (bus.funct3 == 3'd0);
  assign is_ebreak   = sys_f3_zero && (bus.funct12 == 12'h001);
  assign is_mem      = (bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE);
  assign timed_out   = (to_q == TO_LIMIT);

  always_comb begin
    is_legal = 1'b0;
    case (bus.opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_SYSTEM: is_legal = 1'b1;
      default:                                     is_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      to_q       <= '0;
      ret_q      <= '0;
      halt_err_q <= 1'b0;
      br_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_q       <= to_d;
      ret_q      <= ret_d;
      halt_err_q <= halt_err_d;
      br_q       <= br_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    to_d              = to_q;
    ret_d             = ret_q;
    halt_err_d        = halt_err_q;
    br_d              = br_q;
    bus.ifu_req_valid = 1'b0;
    bus.inst_latch_en = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.gpr_w_en      = 1'b0;
    bus.csr_w_en      = 1'b0;
    bus.is_csri       = 1'b0;
    bus.pc_w_en       = 1'b0;
    bus.pc_sel        = 2'd0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        bus.ifu_req_valid = 1'b1;
        if (bus.ifu_resp_valid) begin
          bus.inst_latch_en = 1'b1;
          state_d           = DECODE;
        end else if (timed_out) begin
          state_d    = HALT;
          halt_err_d = 1'b1;
        end
      end

      DECODE: begin
        if (!is_legal) begin
          state_d    = HALT;
          halt_err_d = 1'b1;
        end else if (is_ebreak) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        br_d    = bus.br_taken;
        state_d = is_mem ? MEM_REQ : WB;
      end

      MEM_REQ: begin
        bus.lsu_req_valid = 1'b1;
        if (bus.lsu_req_ready) begin
          state_d = bus.lsu_resp_valid ? WB : MEM_WAIT;
        end else if (timed_out) begin
          state_d    = HALT;
          halt_err_d = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (bus.lsu_resp_valid) begin
          state_d = WB;
        end else if (timed_out) begin
          state_d    = HALT;
          halt_err_d = 1'b1;
        end
      end

      WB: begin
        bus.pc_w_en = 1'b1;
        ret_d       = ret_q + RET_WIDTH'(1);
        state_d     = FETCH;
        case (bus.opcode)
          OP_LUI, OP_AUIPC, OP_LOAD, OP_IMM, OP_OP: bus.gpr_w_en = 1'b1;
          OP_JAL, OP_JALR: begin
            bus.gpr_w_en = 1'b1;
            bus.pc_sel   = 2'd1;
          end
          OP_BRANCH: bus.pc_sel = br_q ? 2'd1 : 2'd0;
          OP_SYSTEM: begin
            bus.gpr_w_en = (bus.funct3 != 3'd0);
            bus.csr_w_en = (bus.funct3 != 3'd0) && (bus.funct3 != 3'd4);
            bus.is_csri  = bus.csr_w_en && bus.funct3[2];
            // Any other funct3=0 encoding (wfi, fences on SYSTEM, ...) retires as a nop.
            if (sys_f3_zero && bus.funct12 == 12'h000) bus.pc_sel = 2'd2;
            else if (sys_f3_zero && bus.funct12 == 12'h302) bus.pc_sel = 2'd3;
          end
          default: ;
        endcase
      end

      HALT: ;

      default: state_d = IDLE;
    endcase

    // The wait budget is shared by MEM_REQ and MEM_WAIT; it only restarts on entry to a request state.
    if ((state_d == FETCH && state_q != FETCH) || (state_d == MEM_REQ && state_q != MEM_REQ)) begin
      to_d = '0;
    end else if (state_q == FETCH || state_q == MEM_REQ || state_q == MEM_WAIT) begin
      to_d = to_q + TO_WIDTH'(1);
    end
  end

  assign bus.halt     = (state_q == HALT);
  assign bus.halt_err = halt_err_q;
  assign bus.minstret = ret_q;

endmodule

// File: tb/tb_ysyx_23060075_core_ctrl.sv
// Self-checking bench for the core sequencer: vector table, hand-written corner sequences,
// and randomized instruction/bus timing against a behavioural model.
module tb_ysyx_23060075_core_ctrl;
  localparam int RW = 8;
  localparam int TO = 4;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                         JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                         ST = 7'b0100011, IMM = 7'b0010011, OPR = 7'b0110011,
                         SYS = 7'b1110011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ret_cnt = 0;

  ysyx_23060075_core_ctrl_if #(.RET_WIDTH(RW)) bus ();

  ysyx_23060075_core_ctrl #(.TIMEOUT(TO), .TO_WIDTH(3), .RET_WIDTH(RW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] f12;
    logic        bt;
    int          fd, rd, wd;
    logic        eg, ec, ei;
    logic [1:0]  es;
    int          kind;   // 0 retire, 1 illegal halt, 2 ebreak halt
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    bus.ifu_resp_valid = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.br_taken       = 1'b0;
    bus.opcode         = 7'd0;
    bus.funct3         = 3'd0;
    bus.funct12        = 12'd0;
  endtask

  function automatic logic [8:0] all_outs();
    return {bus.ifu_req_valid, bus.inst_latch_en, bus.lsu_req_valid, bus.gpr_w_en,
            bus.csr_w_en, bus.is_csri, bus.pc_w_en, bus.halt, bus.halt_err};
  endfunction

  // Ends at a falling edge with the DUT in FETCH.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outs", {all_outs(), bus.pc_sel}, 0);
    chk("reset_minstret", bus.minstret, 0);
    rst = 1'b1;
    #1;
    chk("idle_no_req", bus.ifu_req_valid, 0);
    @(negedge clk);
    ret_cnt = 0;
  endtask

  // Fetch with fd wait cycles, then the DECODE cycle; ends at a falling edge in DECODE.
  task automatic front(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [11:0] f12, input logic bt, input int fd);
    for (int i = 0; i < fd; i++) begin
      bus.ifu_resp_valid = 1'b0;
      #1;
      chk({nm, ".fetch_wait"}, {bus.ifu_req_valid, bus.inst_latch_en, bus.pc_w_en}, 3'b100);
      @(negedge clk);
    end
    bus.opcode = op; bus.funct3 = f3; bus.funct12 = f12;
    bus.ifu_resp_valid = 1'b1;
    #1;
    chk({nm, ".fetch_latch"}, {bus.ifu_req_valid, bus.inst_latch_en}, 2'b11);
    @(negedge clk);
    bus.ifu_resp_valid = 1'b0;
    bus.br_taken = ~bt;
    #1;
    chk({nm, ".decode_quiet"}, {all_outs(), bus.pc_sel}, 0);
  endtask

  task automatic run_instr(input string nm, input vec_t v);
    bit is_mem;
    is_mem = (v.op == LD) || (v.op == ST);
    front(nm, v.op, v.f3, v.f12, v.bt, v.fd);
    if (v.kind != 0) begin
      @(negedge clk);
      #1;
      chk({nm, ".halt"}, all_outs(), {7'b0, 1'b1, (v.kind == 1)});
      bus.ifu_resp_valid = 1'b1;
      bus.lsu_req_ready  = 1'b1;
      bus.lsu_resp_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk({nm, ".halt_hold"}, {all_outs(), bus.pc_sel}, {7'b0, 1'b1, (v.kind == 1), 2'b0});
      idle_inputs();
      return;
    end
    @(negedge clk);
    bus.br_taken = v.bt;
    #1;
    chk({nm, ".exec_quiet"}, {all_outs(), bus.pc_sel}, 0);
    @(negedge clk);
    bus.br_taken = ~v.bt;
    if (is_mem) begin
      for (int i = 0; i < v.rd; i++) begin
        bus.lsu_req_ready = 1'b0;
        #1;
        chk({nm, ".memreq"}, {bus.lsu_req_valid, bus.ifu_req_valid, bus.pc_w_en}, 3'b100);
        @(negedge clk);
      end
      bus.lsu_req_ready  = 1'b1;
      bus.lsu_resp_valid = (v.wd < 0);
      #1;
      chk({nm, ".memreq_acc"}, {bus.lsu_req_valid, bus.halt}, 2'b10);
      @(negedge clk);
      bus.lsu_req_ready  = 1'b0;
      bus.lsu_resp_valid = 1'b0;
      if (v.wd >= 0) begin
        for (int i = 0; i <= v.wd; i++) begin
          bus.lsu_resp_valid = (i == v.wd);
          #1;
          chk({nm, ".memwait"}, {bus.lsu_req_valid, bus.halt, bus.pc_w_en, bus.gpr_w_en}, 0);
          @(negedge clk);
        end
        bus.lsu_resp_valid = 1'b0;
      end
    end
    #1;
    chk({nm, ".wb"}, {bus.gpr_w_en, bus.csr_w_en, bus.is_csri, bus.pc_w_en, bus.pc_sel,
                      bus.ifu_req_valid, bus.lsu_req_valid, bus.halt},
        {v.eg, v.ec, v.ei, 1'b1, v.es, 3'b000});
    ret_cnt = (ret_cnt + 1) % (1 << RW);
    @(negedge clk);
    #1;
    chk({nm, ".minstret"}, bus.minstret, ret_cnt);
    chk({nm, ".refetch"}, {bus.ifu_req_valid, bus.pc_w_en, bus.gpr_w_en}, 3'b100);
  endtask

  // Behavioural expectation from the ISA-level rules.
  function automatic vec_t ref_model(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [11:0] f12, input logic bt);
    vec_t r;
    bit sys0;
    r = '{op: op, f3: f3, f12: f12, bt: bt, fd: 0, rd: 0, wd: 0,
          eg: 0, ec: 0, ei: 0, es: 0, kind: 0};
    sys0 = (op == SYS) && (f3 == 0);
    if (!(op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, IMM, OPR, SYS})) r.kind = 1;
    else if (sys0 && f12 == 12'h001) r.kind = 2;
    r.eg = (op inside {LUI, AUIPC, JAL, JALR, LD, IMM, OPR}) || (op == SYS && f3 != 0);
    r.ec = (op == SYS) && (f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7});
    r.ei = r.ec && (f3 >= 4);
    if (op == JAL || op == JALR || (op == BR && bt)) r.es = 2'd1;
    else if (sys0 && f12 == 12'h000)                  r.es = 2'd2;
    else if (sys0 && f12 == 12'h302)                  r.es = 2'd3;
    return r;
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] f12,
                              input logic bt, input int fd, input int rd, input int wd,
                              input logic eg, input logic ec, input logic ei,
                              input logic [1:0] es, input int kind);
    vec_t v;
    v = '{op: op, f3: f3, f12: f12, bt: bt, fd: fd, rd: rd, wd: wd,
          eg: eg, ec: ec, ei: ei, es: es, kind: kind};
    return v;
  endfunction

  initial begin
    int n;
    logic [6:0] legal_ops [10];
    vec_t v;

    idle_inputs();

    //            op     f3  f12      bt fd rd wd  eg ec ei es kind
    vecs.push_back(mk(IMM,  0, 12'h005, 0, 1, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(LD,   2, 12'h010, 0, 0, 2, 1,  1, 0, 0, 0, 0));
    vecs.push_back(mk(ST,   2, 12'h010, 0, 0, 2, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(BR,   0, 12'h000, 1, 0, 0, 0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(BR,   0, 12'h000, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(SYS,  5, 12'h300, 0, 0, 0, 0,  1, 1, 1, 0, 0));
    vecs.push_back(mk(SYS,  0, 12'h000, 0, 0, 0, 0,  0, 0, 0, 2, 0));
    vecs.push_back(mk(SYS,  0, 12'h302, 0, 0, 0, 0,  0, 0, 0, 3, 0));
    vecs.push_back(mk(JAL,  0, 12'h000, 0, 2, 0, 0,  1, 0, 0, 1, 0));
    vecs.push_back(mk(JALR, 0, 12'h004, 0, 0, 0, 0,  1, 0, 0, 1, 0));
    vecs.push_back(mk(LUI,  1, 12'habc, 1, 0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(AUIPC,0, 12'h000, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(OPR,  0, 12'h000, 1, 0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(SYS,  2, 12'hc00, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk(SYS,  4, 12'h300, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(SYS,  0, 12'h105, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(LD,   0, 12'h000, 0, 0, 0, -1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(IMM,  0, 12'h000, 0, 4, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(ST,   0, 12'h000, 0, 1, 3, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(7'b0000000, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(SYS,  0, 12'h001, 0, 0, 0, 0,  0, 0, 0, 0, 2));
    vecs.push_back(mk(7'b1111111, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    do_reset();
    foreach (vecs[i]) begin
      run_instr($sformatf("vec%0d", i), vecs[i]);
      if (vecs[i].kind != 0) do_reset();
    end

    // Fetch timeout: the request stays up TIMEOUT+1 cycles, then an error halt.
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!bus.ifu_req_valid) break;
      n++;
      @(negedge clk);
    end
    chk("fetch_timeout_cycles", n, TO + 1);
    chk("fetch_timeout_halt", {bus.halt, bus.halt_err, bus.inst_latch_en}, 3'b110);

    // Memory timeout after a slow fetch: the budget restarts on MEM_REQ entry.
    do_reset();
    front("ldto", LD, 3'd2, 12'h0, 1'b0, 3);
    @(negedge clk);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!bus.lsu_req_valid) break;
      n++;
      @(negedge clk);
    end
    chk("mem_timeout_cycles", n, TO + 1);
    chk("mem_timeout_halt", {bus.halt, bus.halt_err, bus.gpr_w_en, bus.pc_w_en}, 4'b1100);

    // Reset pulsed in MEM_WAIT after one retired instruction.
    do_reset();
    run_instr("pre_rst", mk(IMM, 0, 12'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    front("rstld", LD, 3'd2, 12'h0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    bus.lsu_req_ready = 1'b1;
    @(negedge clk);
    bus.lsu_req_ready = 1'b0;
    #1;
    chk("rst_pre_state", {bus.lsu_req_valid, bus.ifu_req_valid, bus.minstret}, {2'b00, 8'd1});
    rst = 1'b0;
    #1;
    chk("rst_async_outs", {all_outs(), bus.pc_sel, bus.minstret}, 0);
    bus.lsu_resp_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_held_quiet", {all_outs(), bus.pc_sel}, 0);
    bus.lsu_resp_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_release_idle", bus.ifu_req_valid, 0);
    @(negedge clk);
    #1;
    chk("rst_fetch_resume", {bus.ifu_req_valid, bus.minstret}, {1'b1, 8'd0});
    idle_inputs();

    // Randomized legal instructions and bus timing; runs long enough to wrap minstret.
    legal_ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, IMM, OPR, SYS};
    do_reset();
    for (int k = 0; k < 300; k++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [11:0] f12;
      op  = legal_ops[$urandom_range(0, 9)];
      f3  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: f12 = 12'h000;
        1: f12 = 12'h302;
        2: f12 = 12'h105;
        default: f12 = 12'($urandom);
      endcase
      if (op == SYS && $urandom_range(0, 1) == 0) f3 = 3'd0;
      if (f12 == 12'h001) f12 = 12'h000;
      v = ref_model(op, f3, f12, 1'($urandom_range(0, 1)));
      v.fd = $urandom_range(0, TO);
      v.rd = $urandom_range(0, TO - 1);
      v.wd = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, TO - 1 - v.rd));
      run_instr($sformatf("rnd%0d", k), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
